// File: rtl/stage_id_pkg.sv
// Shared types and encodings for the instruction-decode stage.
package stage_id_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 6;

  typedef enum logic [2:0] {
    ALU_OP_AND  = 3'd0,
    ALU_OP_OR   = 3'd1,
    ALU_OP_XOR  = 3'd2,
    ALU_OP_ADDS = 3'd3,
    ALU_OP_ADDU = 3'd4,
    ALU_OP_SUBS = 3'd5,
    ALU_OP_SHRL = 3'd6,
    ALU_OP_SHLL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_OP_NONE = 2'd0,
    MEM_OP_LDW  = 2'd1,
    MEM_OP_STW  = 2'd2
  } mem_op_e;

  localparam logic [OP_W-1:0] OP_BE   = 6'h10;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h11;
  localparam logic [OP_W-1:0] OP_JMP  = 6'h14;
  localparam logic [OP_W-1:0] OP_CALL = 6'h15;
  localparam logic [OP_W-1:0] OP_LDW  = 6'h16;
  localparam logic [OP_W-1:0] OP_STW  = 6'h17;

  localparam logic [REG_AW-1:0] REG_LINK = 5'd31;

  // ID/EX pipeline payload; all-zero is the NOP/reset value
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              en;
    alu_op_e           alu_op;
    logic [WORD_W-1:0] alu_in_0;
    logic [WORD_W-1:0] alu_in_1;
    mem_op_e           mem_op;
    logic [WORD_W-1:0] mem_wr_data;
    logic [REG_AW-1:0] dst_addr;
    logic              gpr_we;
    logic              illegal;
  } id_ex_t;

  function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
    return {{(WORD_W-16){v[15]}}, v};
  endfunction

  function automatic logic [WORD_W-1:0] zext16(input logic [15:0] v);
    return {{(WORD_W-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/stage_id_if.sv
// IF <-> ID link: fetched instruction forward, branch redirect back.
interface stage_id_if;
  import stage_id_pkg::*;

  logic [ADDR_W-1:0] if_pc;
  logic [WORD_W-1:0] if_insn;
  logic              if_en;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;

  modport master (output if_pc, if_insn, if_en, input br_taken, br_addr);
  modport slave  (input if_pc, if_insn, if_en, output br_taken, br_addr);
endinterface

// File: rtl/stage_id_reg.sv
// ID/EX pipeline register: stall holds, flush or load-use bubble inserts a NOP.
module stage_id_reg
  import stage_id_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  logic   bubble,
  input  id_ex_t d,
  output id_ex_t q
);

  id_ex_t d_gated;

  // An invalid slot must never carry side effects downstream
  always_comb begin
    d_gated = d;
    if (!d.en) begin
      d_gated.gpr_we  = 1'b0;
      d_gated.mem_op  = MEM_OP_NONE;
      d_gated.illegal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (!stall) begin
      if (flush || bubble) q <= '0;
      else                 q <= d_gated;
    end
  end

endmodule

// File: rtl/stage_id.sv
// Decode stage: field decode, EX/MEM forwarding, branch resolution, load-use detection.
module stage_id
  import stage_id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  stage_id_if.slave         ifid,
  output logic [REG_AW-1:0] gpr_rd_addr_0,
  output logic [REG_AW-1:0] gpr_rd_addr_1,
  input  logic [WORD_W-1:0] gpr_rd_data_0,
  input  logic [WORD_W-1:0] gpr_rd_data_1,
  input  logic              ex_en,
  input  logic              ex_gpr_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [WORD_W-1:0] ex_fwd_data,
  input  logic              mem_en,
  input  logic              mem_gpr_we,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic [WORD_W-1:0] mem_fwd_data,
  output logic              ld_hazard,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_en,
  output logic [2:0]        id_alu_op,
  output logic [WORD_W-1:0] id_alu_in_0,
  output logic [WORD_W-1:0] id_alu_in_1,
  output logic [1:0]        id_mem_op,
  output logic [WORD_W-1:0] id_mem_wr_data,
  output logic [REG_AW-1:0] id_dst_addr,
  output logic              id_gpr_we,
  output logic              id_illegal
);

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] ra, rb, rc;
  logic [15:0]       imm;
  logic [WORD_W-1:0] ra_val, rb_val;
  logic [ADDR_W-1:0] pc_inc;
  alu_op_e           alu_sel;
  logic              use_ra, use_rb, br_cond;
  logic [ADDR_W-1:0] br_tgt;
  id_ex_t            nxt, q;

  assign op      = ifid.if_insn[31:26];
  assign ra      = ifid.if_insn[25:21];
  assign rb      = ifid.if_insn[20:16];
  assign rc      = ifid.if_insn[15:11];
  assign imm     = ifid.if_insn[15:0];
  assign pc_inc  = ifid.if_pc + ADDR_W'(1);
  assign alu_sel = alu_op_e'(op[3:1]);

  assign gpr_rd_addr_0 = ra;
  assign gpr_rd_addr_1 = rb;

  // Youngest producer wins: EX, then MEM, then the register file
  assign ra_val = (ex_en && ex_gpr_we && ex_dst_addr == ra)    ? ex_fwd_data  :
                  (mem_en && mem_gpr_we && mem_dst_addr == ra) ? mem_fwd_data : gpr_rd_data_0;
  assign rb_val = (ex_en && ex_gpr_we && ex_dst_addr == rb)    ? ex_fwd_data  :
                  (mem_en && mem_gpr_we && mem_dst_addr == rb) ? mem_fwd_data : gpr_rd_data_1;

  always_comb begin
    nxt     = '0;
    nxt.pc  = ifid.if_pc;
    nxt.en  = ifid.if_en;
    use_ra  = 1'b0;
    use_rb  = 1'b0;
    br_cond = 1'b0;
    br_tgt  = pc_inc + ADDR_W'(sext16(imm));
    if (op[5:4] == 2'b00) begin
      use_ra       = 1'b1;
      nxt.alu_op   = alu_sel;
      nxt.alu_in_0 = ra_val;
      nxt.gpr_we   = 1'b1;
      if (!op[0]) begin
        use_rb       = 1'b1;
        nxt.alu_in_1 = rb_val;
        nxt.dst_addr = rc;
      end else begin
        nxt.alu_in_1 = (alu_sel == ALU_OP_ADDS || alu_sel == ALU_OP_SUBS) ? sext16(imm) : zext16(imm);
        nxt.dst_addr = rb;
      end
    end else begin
      unique case (op)
        OP_BE, OP_BNE: begin
          use_ra  = 1'b1;
          use_rb  = 1'b1;
          br_cond = (ra_val == rb_val) ^ op[0];
        end
        OP_JMP, OP_CALL: begin
          use_ra  = 1'b1;
          br_cond = 1'b1;
          br_tgt  = ra_val[WORD_W-1:2];
          if (op == OP_CALL) begin
            nxt.alu_op   = ALU_OP_ADDU;
            nxt.alu_in_0 = {pc_inc, 2'b00};
            nxt.dst_addr = REG_LINK;
            nxt.gpr_we   = 1'b1;
          end
        end
        OP_LDW, OP_STW: begin
          use_ra       = 1'b1;
          nxt.alu_op   = ALU_OP_ADDU;
          nxt.alu_in_0 = ra_val;
          nxt.alu_in_1 = sext16(imm);
          if (op == OP_LDW) begin
            nxt.mem_op   = MEM_OP_LDW;
            nxt.dst_addr = rb;
            nxt.gpr_we   = 1'b1;
          end else begin
            use_rb          = 1'b1;
            nxt.mem_op      = MEM_OP_STW;
            nxt.mem_wr_data = rb_val;
          end
        end
        default: nxt.illegal = 1'b1;
      endcase
    end
  end

  assign ld_hazard = ifid.if_en && ex_en && ex_is_load &&
                     ((use_ra && ex_dst_addr == ra) || (use_rb && ex_dst_addr == rb));

  assign ifid.br_taken = ifid.if_en && !ld_hazard && br_cond;
  assign ifid.br_addr  = br_tgt;

  stage_id_reg u_id_reg (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .bubble (ld_hazard),
    .d      (nxt),
    .q      (q)
  );

  assign id_pc          = q.pc;
  assign id_en          = q.en;
  assign id_alu_op      = q.alu_op;
  assign id_alu_in_0    = q.alu_in_0;
  assign id_alu_in_1    = q.alu_in_1;
  assign id_mem_op      = q.mem_op;
  assign id_mem_wr_data = q.mem_wr_data;
  assign id_dst_addr    = q.dst_addr;
  assign id_gpr_we      = q.gpr_we;
  assign id_illegal     = q.illegal;

endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: directed vectors, expected ID/EX contents queued per clock.
module tb_stage_id;
  import stage_id_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, flush;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        ex_en, ex_gpr_we, ex_is_load, mem_en, mem_gpr_we;
  logic [4:0]  ex_dst_addr, mem_dst_addr;
  logic [31:0] ex_fwd_data, mem_fwd_data;
  logic        ld_hazard, id_en, id_gpr_we, id_illegal;
  logic [29:0] id_pc;
  logic [2:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
  logic [1:0]  id_mem_op;
  logic [4:0]  id_dst_addr;
  logic [31:0] regs [32];

  stage_id_if ifid ();

  always #5 clk = ~clk;

  assign gpr_rd_data_0 = regs[gpr_rd_addr_0];
  assign gpr_rd_data_1 = regs[gpr_rd_addr_1];

  stage_id dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ifid(ifid),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en(ex_en), .ex_gpr_we(ex_gpr_we), .ex_is_load(ex_is_load),
    .ex_dst_addr(ex_dst_addr), .ex_fwd_data(ex_fwd_data),
    .mem_en(mem_en), .mem_gpr_we(mem_gpr_we),
    .mem_dst_addr(mem_dst_addr), .mem_fwd_data(mem_fwd_data),
    .ld_hazard(ld_hazard), .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_dst_addr(id_dst_addr),
    .id_gpr_we(id_gpr_we), .id_illegal(id_illegal)
  );

  typedef struct {
    logic [29:0] pc;
    logic        en;
    logic [2:0]  alu_op;
    logic [31:0] in0, in1, wr;
    logic [1:0]  mem_op;
    logic [4:0]  dst;
    logic        we, ill;
    bit          chk_alu, chk_dst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t ea;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [29:0] pc, input logic en, input logic [2:0] alu,
                              input logic [31:0] in0, input logic [31:0] in1, input logic [1:0] mop,
                              input logic [31:0] wr, input logic [4:0] dst, input logic we,
                              input logic ill, input bit ca, input bit cd);
    exp_t e;
    e.pc = pc; e.en = en; e.alu_op = alu; e.in0 = in0; e.in1 = in1; e.mem_op = mop;
    e.wr = wr; e.dst = dst; e.we = we; e.ill = ill; e.chk_alu = ca; e.chk_dst = cd;
    return e;
  endfunction

  function automatic exp_t nop();
    return mk(30'h0, 1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction

  // Monitor: compare the ID/EX register against the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("id_pc", 32'(id_pc), 32'(mon_e.pc));
      check("id_en", 32'(id_en), 32'(mon_e.en));
      check("id_mem_op", 32'(id_mem_op), 32'(mon_e.mem_op));
      check("id_gpr_we", 32'(id_gpr_we), 32'(mon_e.we));
      check("id_illegal", 32'(id_illegal), 32'(mon_e.ill));
      if (mon_e.chk_alu) begin
        check("id_alu_op", 32'(id_alu_op), 32'(mon_e.alu_op));
        check("id_alu_in_0", id_alu_in_0, mon_e.in0);
        check("id_alu_in_1", id_alu_in_1, mon_e.in1);
      end
      if (mon_e.chk_alu && mon_e.mem_op == 2'd2)
        check("id_mem_wr_data", id_mem_wr_data, mon_e.wr);
      if (mon_e.chk_dst)
        check("id_dst_addr", 32'(id_dst_addr), 32'(mon_e.dst));
    end
  end

  task automatic drive(input logic [29:0] pc, input logic [31:0] insn, input logic en);
    ifid.if_pc   = pc;
    ifid.if_insn = insn;
    ifid.if_en   = en;
  endtask

  task automatic clr_fwd();
    ex_en = 0; ex_gpr_we = 0; ex_is_load = 0; ex_dst_addr = 0; ex_fwd_data = 0;
    mem_en = 0; mem_gpr_we = 0; mem_dst_addr = 0; mem_fwd_data = 0;
  endtask

  task automatic step(input bit push, input exp_t e);
    if (push) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_comb(input string tag, input logic hz, input logic bt);
    #1;
    check({tag, " ld_hazard"}, 32'(ld_hazard), 32'(hz));
    check({tag, " br_taken"}, 32'(ifid.br_taken), 32'(bt));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " id_en"}, 32'(id_en), 32'h0);
    check({tag, " id_pc"}, 32'(id_pc), 32'h0);
    check({tag, " id_gpr_we"}, 32'(id_gpr_we), 32'h0);
    check({tag, " id_alu_in_0"}, id_alu_in_0, 32'h0);
    check({tag, " id_alu_in_1"}, id_alu_in_1, 32'h0);
    check({tag, " id_dst_addr"}, 32'(id_dst_addr), 32'h0);
    check({tag, " id_mem_op"}, 32'(id_mem_op), 32'h0);
    check({tag, " id_illegal"}, 32'(id_illegal), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    stall = 0; flush = 0;
    clr_fwd();
    drive(30'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // ADDUI r3,r1,0x0010
    regs[1] = 32'd5;
    drive(30'h40, {6'h09, 5'd1, 5'd3, 16'h0010}, 1'b1);
    chk_comb("addui", 1'b0, 1'b0);
    check("gpr_rd_addr_0", 32'(gpr_rd_addr_0), 32'd1);
    step(1, mk(30'h40, 1, 3'd4, 32'd5, 32'h10, 2'd0, 32'h0, 5'd3, 1, 0, 1, 1));

    // ANDR r5,r1,r2 with EX and MEM both producing r1
    regs[2] = 32'h22;
    ex_en = 1; ex_gpr_we = 1; ex_dst_addr = 5'd1; ex_fwd_data = 32'h77;
    mem_en = 1; mem_gpr_we = 1; mem_dst_addr = 5'd1; mem_fwd_data = 32'h55;
    drive(30'h41, {6'h00, 5'd1, 5'd2, 5'd5, 11'd0}, 1'b1);
    step(1, mk(30'h41, 1, 3'd0, 32'h77, 32'h22, 2'd0, 32'h0, 5'd5, 1, 0, 1, 1));
    ex_en = 0;
    step(1, mk(30'h41, 1, 3'd0, 32'h55, 32'h22, 2'd0, 32'h0, 5'd5, 1, 0, 1, 1));
    clr_fwd();

    // ADDSI sign-extends, ORI zero-extends
    drive(30'h42, {6'h07, 5'd1, 5'd6, 16'hFFFF}, 1'b1);
    step(1, mk(30'h42, 1, 3'd3, 32'd5, 32'hFFFF_FFFF, 2'd0, 32'h0, 5'd6, 1, 0, 1, 1));
    drive(30'h43, {6'h03, 5'd1, 5'd6, 16'h8000}, 1'b1);
    step(1, mk(30'h43, 1, 3'd1, 32'd5, 32'h0000_8000, 2'd0, 32'h0, 5'd6, 1, 0, 1, 1));

    // BE / BNE
    regs[1] = 32'd7; regs[2] = 32'd7;
    drive(30'h100, {6'h10, 5'd1, 5'd2, 16'hFFFE}, 1'b1);
    chk_comb("be_eq", 1'b0, 1'b1);
    check("be br_addr", 32'(ifid.br_addr), 32'h0FF);
    step(1, mk(30'h100, 1, 3'd0, 32'h0, 32'h0, 2'd0, 32'h0, 5'd0, 0, 0, 0, 0));
    regs[2] = 32'd8;
    chk_comb("be_ne", 1'b0, 1'b0);
    drive(30'h100, {6'h11, 5'd1, 5'd2, 16'hFFFE}, 1'b1);
    chk_comb("bne_ne", 1'b0, 1'b1);
    check("bne br_addr", 32'(ifid.br_addr), 32'h0FF);
    regs[2] = 32'd7;
    drive(30'h3FFF_FFFF, {6'h10, 5'd1, 5'd2, 16'h0000}, 1'b1);
    chk_comb("be_wrap", 1'b0, 1'b1);
    check("be_wrap br_addr", 32'(ifid.br_addr), 32'h0);

    // JMP and CALL
    regs[6] = 32'h1234;
    drive(30'h180, {6'h14, 5'd6, 21'd0}, 1'b1);
    chk_comb("jmp", 1'b0, 1'b1);
    check("jmp br_addr", 32'(ifid.br_addr), 32'h48D);
    drive(30'h200, {6'h15, 5'd6, 21'd0}, 1'b1);
    chk_comb("call", 1'b0, 1'b1);
    check("call br_addr", 32'(ifid.br_addr), 32'h48D);
    step(1, mk(30'h200, 1, 3'd0, 32'h0, 32'h0, 2'd0, 32'h0, 5'd31, 1, 0, 0, 1));

    // LDW, then STW with store data forwarded from MEM
    drive(30'h300, {6'h16, 5'd1, 5'd4, 16'hFFFC}, 1'b1);
    step(1, mk(30'h300, 1, 3'd4, 32'd7, 32'hFFFF_FFFC, 2'd1, 32'h0, 5'd4, 1, 0, 1, 1));
    mem_en = 1; mem_gpr_we = 1; mem_dst_addr = 5'd2; mem_fwd_data = 32'h99;
    drive(30'h301, {6'h17, 5'd1, 5'd2, 16'h0008}, 1'b1);
    step(1, mk(30'h301, 1, 3'd4, 32'd7, 32'h8, 2'd2, 32'h99, 5'd0, 0, 0, 1, 0));
    clr_fwd();

    // Load-use hazard on r4
    ex_en = 1; ex_gpr_we = 1; ex_is_load = 1; ex_dst_addr = 5'd4; ex_fwd_data = 32'hDEAD;
    drive(30'h310, {6'h06, 5'd4, 5'd2, 5'd7, 11'd0}, 1'b1);
    chk_comb("hz_addsr", 1'b1, 1'b0);
    step(1, nop());
    drive(30'h311, {6'h10, 5'd4, 5'd4, 16'h0000}, 1'b1);
    chk_comb("hz_be", 1'b1, 1'b0);
    step(1, nop());
    drive(30'h312, {6'h09, 5'd1, 5'd4, 16'h0001}, 1'b1);
    chk_comb("hz_none", 1'b0, 1'b0);
    step(1, mk(30'h312, 1, 3'd4, 32'd7, 32'h1, 2'd0, 32'h0, 5'd4, 1, 0, 1, 1));
    drive(30'h313, {6'h06, 5'd4, 5'd2, 5'd7, 11'd0}, 1'b0);
    chk_comb("hz_ifoff", 1'b0, 1'b0);
    step(1, mk(30'h313, 0, 3'd0, 32'h0, 32'h0, 2'd0, 32'h0, 5'd0, 0, 0, 0, 0));
    clr_fwd();

    // stall wins over flush; flush alone clears
    ea = mk(30'h40, 1, 3'd4, 32'd7, 32'h10, 2'd0, 32'h0, 5'd3, 1, 0, 1, 1);
    drive(30'h40, {6'h09, 5'd1, 5'd3, 16'h0010}, 1'b1);
    step(1, ea);
    drive(30'h44, {6'h03, 5'd2, 5'd9, 16'h00F0}, 1'b1);
    stall = 1; flush = 1;
    step(1, ea);
    stall = 0;
    step(1, nop());
    flush = 0;

    // Undefined opcodes
    drive(30'h50, {6'h3F, 26'h155_5555}, 1'b1);
    chk_comb("ill3f", 1'b0, 1'b0);
    step(1, mk(30'h50, 1, 3'd0, 32'h0, 32'h0, 2'd0, 32'h0, 5'd0, 0, 1, 0, 0));
    drive(30'h51, {6'h12, 5'd1, 5'd1, 16'h0004}, 1'b1);
    chk_comb("ill12", 1'b0, 1'b0);
    step(1, mk(30'h51, 1, 3'd0, 32'h0, 32'h0, 2'd0, 32'h0, 5'd0, 0, 1, 0, 0));

    // Asynchronous reset mid-stream
    drive(30'h60, {6'h09, 5'd1, 5'd3, 16'h0010}, 1'b1);
    step(1, mk(30'h60, 1, 3'd4, 32'd7, 32'h10, 2'd0, 32'h0, 5'd3, 1, 0, 1, 1));
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    drive(30'h61, {6'h14, 5'd6, 21'd0}, 1'b1);
    #1 check("rst jmp br_taken", 32'(ifid.br_taken), 32'h1);
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b1;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
